psum_accumulator: RTL and testbench

- Downstream of the 4-channel PE group. Consumes its four 29-bit signed partial sums (c1..c4_sum) once per input-channel group.
- Accumulates the sums across all channel groups of one output pixel, then adds the bias.
- Applies ReLU, rounding right-shift and saturation to produce a 9-bit signed activation, in the same format as the PE group's data inputs for the next layer.
- Valid/ready handshake on both sides; two-stage pipeline with backpressure.

---
 rtl/psum_accumulator.sv | 154 +++++++++++++++
 tb/tb_psum_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulate PE-group partial sums per pixel, add bias, quantise to an activation
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready          : input beat handshake
//   c1_sum..c4_sum             : signed partial sums, one beat per input-channel group
//   first/last                 : pixel framing; bias and shift are sampled on the last beat
//   out_valid/out_ready        : result handshake
//   out_data                   : signed OUT_W-bit activation
//   grp_err                    : sticky, MAX_GROUPS beats seen without a last
//
// Build option: define PSUM_RELU_EN to clamp negative results to zero before the shift.
module psum_accumulator #(
    parameter int PSUM_W     = 29,
    parameter int ACC_W      = 38,
    parameter int BIAS_W     = 16,
    parameter int OUT_W      = 9,
    parameter int MAX_GROUPS = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PSUM_W-1:0] c1_sum,
    input  logic signed [PSUM_W-1:0] c2_sum,
    input  logic signed [PSUM_W-1:0] c3_sum,
    input  logic signed [PSUM_W-1:0] c4_sum,
    input  logic                     first,
    input  logic                     last,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic [4:0]               shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     grp_err
);

    localparam int S4_W  = PSUM_W + 2;
    localparam int V_W   = ACC_W + 2;
    localparam int CNT_W = $clog2(MAX_GROUPS) + 1;

    localparam logic signed [V_W-1:0] SAT_MAX = V_W'((1 <<< (OUT_W - 1)) - 1);
`ifdef PSUM_RELU_EN
    localparam logic signed [V_W-1:0] SAT_MIN = '0;
`else
    localparam logic signed [V_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    // Stage A registers
    logic                     a_valid;
    logic signed [S4_W-1:0]   a_s4;
    logic                     a_first;
    logic                     a_last;
    logic signed [BIAS_W-1:0] a_bias;
    logic [4:0]               a_shift;

    // Stage B state
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         count;

    logic                     in_fire;
    logic                     b_fire;
    logic                     out_fire;
    logic signed [S4_W-1:0]   tree;
    logic signed [ACC_W-1:0]  acc_new;
    logic [CNT_W-1:0]         cnt_base;
    logic [CNT_W-1:0]         count_new;
    logic signed [V_W-1:0]    v_sum;
    logic signed [V_W-1:0]    v_relu;
    logic signed [V_W-1:0]    v_half;
    logic signed [V_W-1:0]    v_shr;
    logic signed [OUT_W-1:0]  v_sat;

    // A last beat needs the output register free; non-last beats only touch acc.
    assign b_fire   = a_valid && (!a_last || !out_valid || out_ready);
    assign in_ready = !a_valid || b_fire;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign tree = S4_W'(c1_sum) + S4_W'(c2_sum) + S4_W'(c3_sum) + S4_W'(c4_sum);

    assign acc_new = (a_first ? '0 : acc) + ACC_W'(a_s4);

    // Count saturates at MAX_GROUPS so it never wraps back below the error threshold.
    assign cnt_base  = a_first ? '0 : count;
    assign count_new = (cnt_base == CNT_W'(MAX_GROUPS)) ? cnt_base : cnt_base + CNT_W'(1);

    always_comb begin
        v_sum = V_W'(acc_new) + V_W'(a_bias);
`ifdef PSUM_RELU_EN
        v_relu = v_sum[V_W-1] ? '0 : v_sum;
`else
        v_relu = v_sum;
`endif
        // (1 << shift) >> 1 yields the half-LSB rounding term, and zero when shift is 0.
        v_half = (V_W'(1) << a_shift) >> 1;
        v_shr  = (v_relu + v_half) >>> a_shift;
        if (v_shr > SAT_MAX) begin
            v_sat = SAT_MAX[OUT_W-1:0];
        end else if (v_shr < SAT_MIN) begin
            v_sat = SAT_MIN[OUT_W-1:0];
        end else begin
            v_sat = v_shr[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_valid   <= 1'b0;
            a_s4      <= '0;
            a_first   <= 1'b0;
            a_last    <= 1'b0;
            a_bias    <= '0;
            a_shift   <= '0;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            grp_err   <= 1'b0;
        end else begin
            if (in_fire) begin
                a_valid <= 1'b1;
                a_s4    <= tree;
                a_first <= first;
                a_last  <= last;
                a_bias  <= bias;
                a_shift <= shift;
            end else if (b_fire) begin
                a_valid <= 1'b0;
            end

            if (b_fire) begin
                if (a_last) begin
                    acc   <= '0;
                    count <= '0;
                end else begin
                    acc   <= acc_new;
                    count <= count_new;
                    if (count_new == CNT_W'(MAX_GROUPS)) begin
                        grp_err <= 1'b1;
                    end
                end
            end

            if (b_fire && a_last) begin
                out_data  <= v_sat;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed self-checking bench for psum_accumulator
module tb_psum_accumulator;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [28:0] c1_sum = '0;
    logic signed [28:0] c2_sum = '0;
    logic signed [28:0] c3_sum = '0;
    logic signed [28:0] c4_sum = '0;
    logic               first = 1'b0;
    logic               last = 1'b0;
    logic signed [15:0] bias = '0;
    logic [4:0]         shift = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [8:0]  out_data;
    logic               grp_err;

    int n_checks = 0;
    int n_fail = 0;
    int got_q[$];
    int exp_q[$];

    psum_accumulator #(.MAX_GROUPS(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .c1_sum(c1_sum), .c2_sum(c2_sum), .c3_sum(c3_sum), .c4_sum(c4_sum),
        .first(first), .last(last), .bias(bias), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .grp_err(grp_err)
    );

    always #5 clk = ~clk;

    // Record every accepted result, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) got_q.push_back(int'($signed(out_data)));
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input int s1, input int s2, input int s3, input int s4,
                        input bit f, input bit l, input int b, input int sh);
        bit done = 1'b0;
        c1_sum = s1[28:0]; c2_sum = s2[28:0]; c3_sum = s3[28:0]; c4_sum = s4[28:0];
        first = f; last = l; bias = b[15:0]; shift = sh[4:0];
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            done = in_ready;
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && got_q.size() < exp_q.size(); i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // {sum, bias, shift, expected without ReLU, expected with ReLU}
    int sat_tv[13][5] = '{
        '{ 100000,    0, 0,  255, 255},
        '{    -50,    0, 0,  -50,   0},
        '{-100000,    0, 0, -256,   0},
        '{     24,    0, 4,    2,   2},
        '{     23,    0, 4,    1,   1},
        '{    -24,    0, 4,   -1,   0},
        '{    256,    0, 0,  255, 255},
        '{   -257,    0, 0, -256,   0},
        '{   -256,    0, 0, -256,   0},
        '{      0, -300, 0, -256,   0},
        '{      0,  200, 1,  100, 100},
        '{    510,    0, 1,  255, 255},
        '{    512,    0, 1,  255, 255}
    };

    initial begin
        bit saw_stall;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_grp_err", grp_err, 0);
        reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Single group, latency of two cycles
        send(10, 20, 30, 40, 1, 1, 0, 0);
        check("lat_n1_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_n2_valid", out_valid, 1);
        check("lat_n2_data", out_data, 100);
        exp_q.push_back(100);
        drain("single");

        // Three groups, bias and rounding shift: (2600 + 8) >>> 4 = 163
        send(250, 250, 250, 250, 1, 0, 0, 0);
        send(500, 500, 500, 500, 0, 0, 0, 0);
        send(-125, -125, -125, -125, 0, 1, 100, 4);
        exp_q.push_back(163);
        drain("three_grp");

        // Saturation, rounding and ReLU boundaries
        for (int i = 0; i < 13; i++) begin
            send(sat_tv[i][0], 0, 0, 0, 1, 1, sat_tv[i][1], sat_tv[i][2]);
`ifdef PSUM_RELU_EN
            exp_q.push_back(sat_tv[i][4]);
`else
            exp_q.push_back(sat_tv[i][3]);
`endif
        end
        drain("sat");

        // Backpressure: first result held while two 2-group pixels stream behind it
        out_ready = 1'b0;
        saw_stall = 1'b0;
        fork
            begin
                send(1, 2, 2, 2, 1, 1, 0, 0);
                send(10, 10, 10, 10, 1, 0, 0, 0);
                send(15, 15, 15, 15, 0, 1, -4, 1);
                send(75, 75, 75, 75, 1, 0, 0, 0);
                send(53, 53, 53, 53, 0, 1, 0, 2);
            end
            begin
                for (int i = 0; i < 20 && !out_valid; i++) begin
                    @(posedge clk); #1;
                end
                for (int i = 0; i < 5; i++) begin
                    check("bp_hold_valid", out_valid, 1);
                    check("bp_hold_data", out_data, 7);
                    if (!in_ready) saw_stall = 1'b1;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        check("bp_in_ready_drop", saw_stall, 1);
        exp_q.push_back(7);
        exp_q.push_back(48);
        exp_q.push_back(128);
        drain("bp");

        // Group overflow with MAX_GROUPS = 4
        for (int k = 1; k <= 5; k++) begin
            send(1, 0, 0, 0, k == 1, 0, 0, 0);
            @(posedge clk); #1;
            check($sformatf("grp_err_beat%0d", k), grp_err, (k >= 4) ? 1 : 0);
        end
        send(1, 1, 1, 1, 1, 1, 0, 0);
        exp_q.push_back(4);
        drain("after_err");
        check("grp_err_sticky", grp_err, 1);

        // Reset mid-pixel with a result pending
        out_ready = 1'b0;
        send(2, 2, 2, 2, 1, 1, 0, 0);
        send(250, 250, 250, 250, 1, 0, 0, 0);
        send(500, 500, 500, 500, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_grp_err", grp_err, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        send(1, 1, 1, 1, 0, 1, 0, 0);
        exp_q.push_back(4);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
